midi_voice_allocator: RTL and testbench
=======================================

// Module: midi_voice_allocator
// PURPOSE
//  Polyphonic voice scheduler between the MIDI shift register and the per-voice pitch/velocity chain.
//  Takes decoded 3-byte MIDI messages and assigns Note On events to a free stepper voice.
//  Steals the oldest voice when all are busy, and releases voices on Note Off or All Notes Off.
//  Its per-voice note and velocity buses feed the pitch-conversion and velocity-routing stages.
// PARAMETERS
//  N_VOICES   8        number of stepper voices managed (2..16)
//  AGE_W      4        width of per-voice age counter (saturating)
//  CHAN_MASK  16'hFFFF bit c=1 -> MIDI channel c accepted; other channels dropped
// PORTS
//  Clk           in   1          system clock
//  Rst_p         in   1          synchronous reset, active-high
//  Msg_valid     in   1          Msg_data holds a complete message
//  Msg_data      in   24         [23:16] status, [15:8] note, [7:0] velocity
//  Msg_ready     out  1          high when block can accept a message (state IDLE)
//  Voice_active  out  N_VOICES   bit v=1 -> voice v sounding
//  Voice_note    out  7*N_VOICES voice v note at [7v+6:7v]
//  Voice_vel     out  7*N_VOICES voice v velocity; 0 when released
//  Voice_chan    out  4*N_VOICES MIDI channel owning voice v
//  Voice_update  out  N_VOICES   1-cycle strobe, voice v written this cycle
//  Steal         out  1          1-cycle strobe, Note On stole an active voice
// BEHAVIOUR
//  Reset: all outputs 0, all ages 0, state IDLE; Msg_ready=1 on first cycle after Rst_p low.
//  Reset mid-scan: message abandoned, no voice written.
//  Accept: at edge where Msg_valid&Msg_ready; status/note/vel registered; input ignored elsewhere.
//  Decode (applied to registered copy, ch = status[3:0], data bits [7] ignored):
//   - 0x9n vel!=0 -> NOTE_ON; 0x8n, or 0x9n vel==0 -> NOTE_OFF.
//   - 0xBn note==0x7B -> ALL_OFF; anything else, or CHAN_MASK[ch]==0 -> DROP.
//  FSM: IDLE -> SCAN (N_VOICES cycles, idx 0..N-1) -> COMMIT (1 cycle) -> IDLE.
//   - DROP: IDLE->IDLE, no output change.
//   - ALL_OFF: IDLE->COMMIT directly.
//  SCAN: one voice compared per cycle, lowest index wins ties. Tracks:
//   - match: active & note & chan equal
//   - first free: !active
//   - oldest: active, max age
//  COMMIT, NOTE_ON, priority order:
//   1. match  -> retrigger: velocity rewritten, age reset to 0.
//   2. free   -> note/vel/chan written, active set, age 0.
//   3. oldest -> overwritten, Steal pulses this cycle.
//   - Other active voices: age += 1, saturating at 2^AGE_W-1.
//  COMMIT, NOTE_OFF: every matching voice -> active=0, vel=0; note/chan retained; ages untouched.
//   - No match -> no change, no strobe.
//  COMMIT, ALL_OFF: every voice with chan==ch released as NOTE_OFF.
//  Voice_update: asserted in COMMIT for each voice whose regs change; outputs visible next cycle.
//  Latency: accept edge k -> outputs updated at edge k+N_VOICES+2; ALL_OFF at edge k+2.
//   - Msg_ready low from edge k until the same edge the outputs update.
//  All output regs update only in COMMIT or reset; no combinational path from Msg_* to outputs.
// TESTING
//  1. Reset, Note On 0x90/60/100 -> after N+2 cycles voice0 active, note 60, vel 100; strobe bit0.
//  2. Fill 8 voices with notes 60..67, then note 70 -> voice0 (oldest) gets 70; Steal=1 one cycle.
//  3. Note On 64 twice (vel 50, then 90) -> one voice only, vel 90; no other voice changes.
//  4. 0x80/62 and 0x90/62/0 on active note -> voice released (active 0, vel 0, note 62 kept).
//  5. Voices on ch0 and ch1, then 0xB1/0x7B/0 -> only ch1 voices released at edge k+2.
//  6. CHAN_MASK=16'h0001, 0x92/60/100 -> dropped: Msg_ready stays 1, outputs unchanged.
//     Rst_p mid-SCAN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/midi_voice_allocator.sv
// Polyphonic MIDI voice scheduler: serial scan picks retrigger/free/oldest voice for Note On and releases on Note Off/All Notes Off.
// Accept edge k -> outputs at k+N_VOICES+2 (All Notes Off k+2); msg_ready_o low while busy, dropped messages keep it high.
module midi_voice_allocator #(
    parameter int          N_VOICES  = 8,
    parameter int          AGE_W     = 4,
    parameter logic [15:0] CHAN_MASK = 16'hFFFF
) (
    input  logic                  clk_i,
    input  logic                  rst_p_i,
    input  logic                  msg_valid_i,
    input  logic [23:0]           msg_data_i,
    output logic                  msg_ready_o,
    output logic [N_VOICES-1:0]   voice_active_o,
    output logic [7*N_VOICES-1:0] voice_note_o,
    output logic [7*N_VOICES-1:0] voice_vel_o,
    output logic [4*N_VOICES-1:0] voice_chan_o,
    output logic [N_VOICES-1:0]   voice_update_o,
    output logic                  steal_o
);
    localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_SCAN, S_COMMIT} state_t;
    typedef enum logic [1:0] {OP_ON, OP_OFF, OP_ALL, OP_DROP} op_t;

    state_t              state_q;
    op_t                 op_q;
    op_t                 in_op;
    logic [3:0]          mch_q;
    logic [6:0]          mnote_q;
    logic [6:0]          mvel_q;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    match_idx_q;
    logic [IDX_W-1:0]    free_idx_q;
    logic [IDX_W-1:0]    old_idx_q;
    logic [IDX_W-1:0]    tgt;
    logic                match_vld_q;
    logic                free_vld_q;
    logic                old_vld_q;
    logic [AGE_W-1:0]    old_age_q;

    logic [N_VOICES-1:0] active_q, active_d;
    logic [N_VOICES-1:0] upd_q, upd_d;
    logic [6:0]          note_q [N_VOICES];
    logic [6:0]          note_d [N_VOICES];
    logic [6:0]          vel_q  [N_VOICES];
    logic [6:0]          vel_d  [N_VOICES];
    logic [3:0]          chan_q [N_VOICES];
    logic [3:0]          chan_d [N_VOICES];
    logic [AGE_W-1:0]    age_q  [N_VOICES];
    logic [AGE_W-1:0]    age_d  [N_VOICES];
    logic                steal_q, steal_d;
    logic                unused_data_bits;

    // Decoding at the accept edge lets dropped messages leave the FSM idle.
    always_comb begin
        in_op = OP_DROP;
        if (CHAN_MASK[msg_data_i[19:16]]) begin
            case (msg_data_i[23:20])
                4'h9:    in_op = (msg_data_i[6:0] != 7'd0) ? OP_ON : OP_OFF;
                4'h8:    in_op = OP_OFF;
                4'hB:    in_op = (msg_data_i[14:8] == 7'h7B) ? OP_ALL : OP_DROP;
                default: in_op = OP_DROP;
            endcase
        end
    end

    assign tgt = match_vld_q ? match_idx_q : (free_vld_q ? free_idx_q : old_idx_q);

    always_comb begin
        active_d = active_q;
        note_d   = note_q;
        vel_d    = vel_q;
        chan_d   = chan_q;
        age_d    = age_q;
        upd_d    = '0;
        steal_d  = 1'b0;
        case (op_q)
            OP_ON: begin
                steal_d = !match_vld_q && !free_vld_q;
                for (int v = 0; v < N_VOICES; v++) begin
                    if (IDX_W'(v) == tgt) begin
                        active_d[v] = 1'b1;
                        note_d[v]   = mnote_q;
                        vel_d[v]    = mvel_q;
                        chan_d[v]   = mch_q;
                        age_d[v]    = '0;
                        upd_d[v]    = 1'b1;
                    end else if (active_q[v] && !(&age_q[v])) begin
                        age_d[v] = age_q[v] + AGE_W'(1);
                    end
                end
            end
            OP_OFF, OP_ALL: begin
                for (int v = 0; v < N_VOICES; v++) begin
                    if (active_q[v] && chan_q[v] == mch_q &&
                        (op_q == OP_ALL || note_q[v] == mnote_q)) begin
                        active_d[v] = 1'b0;
                        vel_d[v]    = '0;
                        upd_d[v]    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_p_i) begin
            state_q     <= S_IDLE;
            op_q        <= OP_DROP;
            mch_q       <= '0;
            mnote_q     <= '0;
            mvel_q      <= '0;
            idx_q       <= '0;
            match_idx_q <= '0;
            free_idx_q  <= '0;
            old_idx_q   <= '0;
            match_vld_q <= 1'b0;
            free_vld_q  <= 1'b0;
            old_vld_q   <= 1'b0;
            old_age_q   <= '0;
            active_q    <= '0;
            upd_q       <= '0;
            steal_q     <= 1'b0;
            for (int v = 0; v < N_VOICES; v++) begin
                note_q[v] <= '0;
                vel_q[v]  <= '0;
                chan_q[v] <= '0;
                age_q[v]  <= '0;
            end
        end else begin
            upd_q   <= '0;
            steal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (msg_valid_i && in_op != OP_DROP) begin
                        op_q    <= in_op;
                        mch_q   <= msg_data_i[19:16];
                        mnote_q <= msg_data_i[14:8];
                        mvel_q  <= msg_data_i[6:0];
                        state_q <= S_PREP;
                    end
                end
                S_PREP: begin
                    idx_q       <= '0;
                    match_vld_q <= 1'b0;
                    free_vld_q  <= 1'b0;
                    old_vld_q   <= 1'b0;
                    state_q     <= (op_q == OP_ALL) ? S_COMMIT : S_SCAN;
                end
                S_SCAN: begin
                    if (!match_vld_q && active_q[idx_q] && note_q[idx_q] == mnote_q &&
                        chan_q[idx_q] == mch_q) begin
                        match_vld_q <= 1'b1;
                        match_idx_q <= idx_q;
                    end
                    if (!free_vld_q && !active_q[idx_q]) begin
                        free_vld_q <= 1'b1;
                        free_idx_q <= idx_q;
                    end
                    // Strict compare keeps the lowest index among equally old voices.
                    if (active_q[idx_q] && (!old_vld_q || age_q[idx_q] > old_age_q)) begin
                        old_vld_q <= 1'b1;
                        old_idx_q <= idx_q;
                        old_age_q <= age_q[idx_q];
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_COMMIT;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                S_COMMIT: begin
                    active_q <= active_d;
                    note_q   <= note_d;
                    vel_q    <= vel_d;
                    chan_q   <= chan_d;
                    age_q    <= age_d;
                    upd_q    <= upd_d;
                    steal_q  <= steal_d;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign msg_ready_o      = (state_q == S_IDLE);
    assign voice_active_o   = active_q;
    assign voice_update_o   = upd_q;
    assign steal_o          = steal_q;
    assign unused_data_bits = msg_data_i[15] ^ msg_data_i[7];

    for (genvar v = 0; v < N_VOICES; v++) begin : g_pack
        assign voice_note_o[7*v +: 7] = note_q[v];
        assign voice_vel_o[7*v +: 7]  = vel_q[v];
        assign voice_chan_o[4*v +: 4] = chan_q[v];
    end
endmodule

// File: tb/tb_midi_voice_allocator.sv
// Bench for midi_voice_allocator: message-level voice model predicts outputs per cycle,
// directed literal checks pin the model, then randomized traffic with junk during busy periods.
module tb_midi_voice_allocator;
    localparam int          N    = 8;
    localparam int          AW   = 4;
    localparam logic [15:0] MASK = 16'hBF0B;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           msg_valid = 1'b0;
    logic [23:0]    msg_data = '0;
    logic           msg_ready;
    logic [N-1:0]   voice_active, voice_update;
    logic [7*N-1:0] voice_note, voice_vel;
    logic [4*N-1:0] voice_chan;
    logic           steal;

    midi_voice_allocator #(.N_VOICES(N), .AGE_W(AW), .CHAN_MASK(MASK)) dut (
        .clk_i(clk), .rst_p_i(rst), .msg_valid_i(msg_valid), .msg_data_i(msg_data),
        .msg_ready_o(msg_ready), .voice_active_o(voice_active), .voice_note_o(voice_note),
        .voice_vel_o(voice_vel), .voice_chan_o(voice_chan), .voice_update_o(voice_update),
        .steal_o(steal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Voice model state after every accepted message.
    bit     m_act  [N];
    int     m_note [N];
    int     m_vel  [N];
    int     m_chan [N];
    int     m_age  [N];
    logic [N-1:0] m_upd;
    bit     m_steal;

    typedef struct {
        int             vis;
        logic [N-1:0]   act;
        logic [N-1:0]   upd;
        logic [7*N-1:0] note;
        logic [7*N-1:0] vel;
        logic [4*N-1:0] chan;
        bit             steal;
    } pend_t;
    pend_t pend_q[$];

    logic [N-1:0]   e_act = '0, e_upd = '0;
    logic [7*N-1:0] e_note = '0, e_vel = '0;
    logic [4*N-1:0] e_chan = '0;
    bit             e_steal = 1'b0;
    int vis_cyc = 0, acc_cyc = 0, r_from = 0, r_to = 0;

    function automatic pend_t pack();
        pend_t p;
        p.vis = 0;
        for (int v = 0; v < N; v++) begin
            p.act[v]         = m_act[v];
            p.note[7*v +: 7] = 7'(m_note[v]);
            p.vel[7*v +: 7]  = 7'(m_vel[v]);
            p.chan[4*v +: 4] = 4'(m_chan[v]);
        end
        p.upd   = m_upd;
        p.steal = m_steal;
        return p;
    endfunction

    // kind: 0 drop, 1 note on, 2 note off, 3 all notes off
    task automatic apply_msg(input logic [23:0] m, output int kind);
        logic [15:0] mask_v;
        int st, ch, nt, vl, tgt;
        mask_v = MASK;
        st = int'(m[23:20]); ch = int'(m[19:16]); nt = int'(m[14:8]); vl = int'(m[6:0]);
        if (!mask_v[ch])                  kind = 0;
        else if (st == 9 && vl != 0)      kind = 1;
        else if (st == 9 || st == 8)      kind = 2;
        else if (st == 11 && nt == 'h7B)  kind = 3;
        else                              kind = 0;
        m_upd = '0;
        m_steal = 1'b0;
        if (kind == 1) begin
            tgt = -1;
            for (int v = 0; v < N; v++)
                if (tgt < 0 && m_act[v] && m_note[v] == nt && m_chan[v] == ch) tgt = v;
            for (int v = 0; v < N; v++)
                if (tgt < 0 && !m_act[v]) tgt = v;
            if (tgt < 0) begin
                m_steal = 1'b1;
                tgt = 0;
                for (int v = 1; v < N; v++)
                    if (m_age[v] > m_age[tgt]) tgt = v;
            end
            for (int v = 0; v < N; v++) begin
                if (v == tgt) begin
                    m_act[v] = 1'b1; m_note[v] = nt; m_vel[v] = vl; m_chan[v] = ch;
                    m_age[v] = 0; m_upd[v] = 1'b1;
                end else if (m_act[v] && m_age[v] < (1 << AW) - 1) begin
                    m_age[v]++;
                end
            end
        end else if (kind == 2 || kind == 3) begin
            for (int v = 0; v < N; v++)
                if (m_act[v] && m_chan[v] == ch && (kind == 3 || m_note[v] == nt)) begin
                    m_act[v] = 1'b0; m_vel[v] = 0; m_upd[v] = 1'b1;
                end
        end
    endtask

    task automatic send(input logic [23:0] m, output int kind);
        pend_t p;
        forever begin
            @(posedge clk); #1;
            if (cyc >= vis_cyc) break;
            msg_valid = 1'($urandom_range(0, 1));
            msg_data  = 24'($urandom);
        end
        msg_valid = 1'b1;
        msg_data  = m;
        acc_cyc   = cyc + 1;
        apply_msg(m, kind);
        if (kind != 0) begin
            vis_cyc = acc_cyc + ((kind == 3) ? 2 : N + 2);
            r_from  = acc_cyc;
            r_to    = vis_cyc;
            p       = pack();
            p.vis   = vis_cyc;
            pend_q.push_back(p);
        end
        @(posedge clk); #1;
        msg_valid = 1'b0;
        msg_data  = 24'($urandom);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        msg_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int v = 0; v < N; v++) begin
            m_act[v] = 0; m_note[v] = 0; m_vel[v] = 0; m_chan[v] = 0; m_age[v] = 0;
        end
        pend_q.delete();
        e_act = '0; e_note = '0; e_vel = '0; e_chan = '0;
        vis_cyc = 0; r_from = 0; r_to = 0;
    endtask

    task automatic wait_vis();
        int g = 0;
        @(negedge clk);
        while (cyc < vis_cyc && g < 40) begin
            @(negedge clk);
            g++;
        end
    endtask

    task automatic wait_update(output int lat);
        int g = 0;
        lat = -1;
        do begin
            @(negedge clk);
            g++;
        end while (voice_update == '0 && g < 40);
        if (voice_update != '0) lat = cyc - acc_cyc;
    endtask

    function automatic int vnote(input int v); return int'(voice_note[7*v +: 7]); endfunction
    function automatic int vvel(input int v);  return int'(voice_vel[7*v +: 7]);  endfunction
    function automatic int vchan(input int v); return int'(voice_chan[4*v +: 4]); endfunction

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            e_upd   = '0;
            e_steal = 1'b0;
            if (pend_q.size() > 0 && pend_q[0].vis == cyc) begin
                e_act = pend_q[0].act; e_note = pend_q[0].note; e_vel = pend_q[0].vel;
                e_chan = pend_q[0].chan; e_upd = pend_q[0].upd; e_steal = pend_q[0].steal;
                void'(pend_q.pop_front());
            end
            chk("active", voice_active, e_act);
            chk("note", voice_note, e_note);
            chk("vel", voice_vel, e_vel);
            chk("chan", voice_chan, e_chan);
            chk("update", voice_update, e_upd);
            chk("steal", steal, e_steal);
            chk("ready", msg_ready, !(cyc >= r_from && cyc < r_to));
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog cyc=%0d got=timeout expected=completion", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int k, lat, r, st, ch, nt, vl;
        logic [23:0] m;
        for (int v = 0; v < N; v++) begin
            m_act[v] = 0; m_note[v] = 0; m_vel[v] = 0; m_chan[v] = 0; m_age[v] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_active", voice_active, 0);
        chk("rst_ready", msg_ready, 1);
        chk("rst_note", voice_note, 0);

        send(24'h903C64, k);
        wait_update(lat);
        chk("t1_latency", lat, N + 2);
        chk("t1_active", voice_active, 8'h01);
        chk("t1_note0", vnote(0), 60);
        chk("t1_vel0", vvel(0), 100);
        chk("t1_update", voice_update, 8'h01);

        for (int n = 61; n <= 67; n++) send({8'h90, 8'(n), 8'h64}, k);
        send(24'h904664, k);
        wait_vis();
        chk("t2_steal", steal, 1);
        chk("t2_note0", vnote(0), 70);
        chk("t2_active", voice_active, 8'hFF);
        chk("t2_update", voice_update, 8'h01);

        send(24'h904032, k);
        send(24'h90405A, k);
        wait_vis();
        chk("t3_vel4", vvel(4), 90);
        chk("t3_update", voice_update, 8'h10);
        chk("t3_steal", steal, 0);

        send(24'h803E00, k);
        wait_vis();
        chk("t4_active", voice_active, 8'hFB);
        chk("t4_vel2", vvel(2), 0);
        chk("t4_note2", vnote(2), 62);
        send(24'h903F00, k);
        wait_vis();
        chk("t4_update", voice_update, 8'h08);

        send(24'h915014, k);
        send(24'h915128, k);
        wait_vis();
        chk("t5_chan3", vchan(3), 1);
        send(24'hB17B00, k);
        wait_update(lat);
        chk("t5_latency", lat, 2);
        chk("t5_active", voice_active, 8'hF3);
        chk("t5_update", voice_update, 8'h0C);
        chk("t5_note2", vnote(2), 80);

        send(24'h923C64, k);
        @(negedge clk);
        chk("t6_ready", msg_ready, 1);
        repeat (3) @(negedge clk);
        chk("t6_active", voice_active, 8'hF3);

        for (int i = 0; i < 400; i++) begin
            r  = $urandom_range(0, 99);
            ch = $urandom_range(0, 5);
            ch = (ch < 4) ? ch : ((ch == 4) ? 8 : 14);
            nt = 60 + $urandom_range(0, 9);
            vl = $urandom_range(1, 127);
            if (r < 45)      st = 9;
            else if (r < 55) begin st = 9; vl = 0; end
            else if (r < 80) st = 8;
            else if (r < 86) begin st = 11; nt = 'h7B; end
            else if (r < 92) st = 11;
            else             st = $urandom_range(10, 15);
            m = {4'(st), 4'(ch), 1'($urandom_range(0, 1)), 7'(nt), 1'($urandom_range(0, 1)), 7'(vl)};
            send(m, k);
        end

        send(24'h903C64, k);
        repeat (4) @(posedge clk);
        do_reset();
        @(negedge clk);
        chk("rstmid_active", voice_active, 0);
        chk("rstmid_update", voice_update, 0);
        chk("rstmid_ready", msg_ready, 1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
